// File: rtl/target_sequencer.sv
// Purpose : finds a valid target position, arms it, and keeps score as the snake head collects targets.
// Latency : GEN_ADVANCE to TARGET_VALID is 5 cycles with occupancy checking, 3 cycles without.
// Backpressure: none. The generator and the occupancy lookup respond on fixed timing, so there is no stall path.
//
// Build option: define TARGET_SEQ_OCC_CHECK_EN to enable the snake-body occupancy lookup
// (QUERY/WAIT_OCC). When it is undefined, in-bounds candidates are accepted straight
// from CHECK, OCC_* outputs are tied to 0 and body_hit is ignored.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   game_run                level, high while the game is playing
//   head_x/head_y           current snake head address
//   gen_addr_x/gen_addr_y   candidate address from the target generator
//   gen_advance             one-cycle pulse asking the generator for a new address
//   occ_query/occ_x/occ_y   occupancy lookup request and address
//   body_hit                lookup result, valid one cycle after occ_query
//   target_x/target_y       accepted target address (registered)
//   target_valid            target is live on the playfield
//   score/score_event       targets collected, and a pulse per collection
//   game_won                sticky win flag, cleared only by reset
module target_sequencer #(
  parameter int unsigned MAX_X       = 160,
  parameter int unsigned MAX_Y       = 120,
  parameter int unsigned WIN_SCORE   = 10,
  parameter int unsigned RETRY_LIMIT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_run,
  input  logic [7:0] head_x,
  input  logic [6:0] head_y,
  input  logic [7:0] gen_addr_x,
  input  logic [6:0] gen_addr_y,
  output logic       gen_advance,
  output logic       occ_query,
  output logic [7:0] occ_x,
  output logic [6:0] occ_y,
  input  logic       body_hit,
  output logic [7:0] target_x,
  output logic [6:0] target_y,
  output logic       target_valid,
  output logic [3:0] score,
  output logic       score_event,
  output logic       game_won
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADVANCE,
    S_SETTLE,
    S_CHECK,
    S_QUERY,
    S_WAIT_OCC,
    S_ARMED,
    S_HIT,
    S_WON
  } state_t;

  // Bounds are compared one bit wider than the address so that a bound equal to
  // 2^width (every address valid) does not wrap to zero.
  localparam logic [8:0] MAX_X_W = 9'(MAX_X);
  localparam logic [7:0] MAX_Y_W = 8'(MAX_Y);
  localparam logic [7:0] FB_X    = 8'(MAX_X / 2);
  localparam logic [6:0] FB_Y    = 7'(MAX_Y / 2);
  localparam logic [3:0] WIN_L   = 4'(WIN_SCORE);
  localparam logic [3:0] RETRY_L = 4'(RETRY_LIMIT);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] retry_cnt;
  logic [3:0] retry_nxt;
  logic [3:0] retry_inc;
  logic [7:0] cand_x;
  logic [6:0] cand_y;
  logic       cand_ld;
  logic       accept;
  logic       reject;
  logic [7:0] tgt_x_nxt;
  logic [6:0] tgt_y_nxt;
  logic       score_inc;
  logic       gen_oob;

  assign retry_inc = retry_cnt + 4'd1;
  assign gen_oob   = ({1'b0, gen_addr_x} >= MAX_X_W) || ({1'b0, gen_addr_y} >= MAX_Y_W);

  always_comb begin
    state_nxt = state;
    retry_nxt = retry_cnt;
    cand_ld   = 1'b0;
    accept    = 1'b0;
    reject    = 1'b0;
    tgt_x_nxt = cand_x;
    tgt_y_nxt = cand_y;
    score_inc = 1'b0;

    // Dropping game_run wins over everything, including a head match in ARMED,
    // so no score is taken on the cycle the game stops. WON is terminal.
    if (state != S_WON && !game_run) begin
      state_nxt = S_IDLE;
      retry_nxt = '0;
    end else begin
      case (state)
        S_IDLE:    state_nxt = S_ADVANCE;
        S_ADVANCE: state_nxt = S_SETTLE;
        S_SETTLE:  state_nxt = S_CHECK;
        S_CHECK: begin
          cand_ld = 1'b1;
          if (gen_oob) begin
            reject = 1'b1;
          end else begin
`ifdef TARGET_SEQ_OCC_CHECK_EN
            state_nxt = S_QUERY;
`else
            // The candidate register loads on this same edge, so take the address
            // straight from the generator.
            accept    = 1'b1;
            tgt_x_nxt = gen_addr_x;
            tgt_y_nxt = gen_addr_y;
`endif
          end
        end
`ifdef TARGET_SEQ_OCC_CHECK_EN
        S_QUERY: state_nxt = S_WAIT_OCC;
        S_WAIT_OCC: begin
          if (body_hit) begin
            reject = 1'b1;
          end else begin
            accept = 1'b1;
          end
        end
`endif
        S_ARMED: begin
          if (head_x == target_x && head_y == target_y) begin
            state_nxt = S_HIT;
            score_inc = 1'b1;
          end
        end
        // Score already holds the incremented value during HIT.
        S_HIT:   state_nxt = (score == WIN_L) ? S_WON : S_ADVANCE;
        S_WON:   state_nxt = S_WON;
        default: state_nxt = S_IDLE;
      endcase

      // The rejection that reaches the limit is turned into an acceptance of the
      // playfield centre, so the search always terminates.
      if (reject) begin
        if (retry_inc == RETRY_L) begin
          accept    = 1'b1;
          tgt_x_nxt = FB_X;
          tgt_y_nxt = FB_Y;
        end else begin
          retry_nxt = retry_inc;
          state_nxt = S_ADVANCE;
        end
      end

      if (accept) begin
        retry_nxt = '0;
        state_nxt = S_ARMED;
      end
    end
  end

  // The pulse and flag outputs are registered decodes of the next state, so each
  // one is high for exactly the cycles the FSM spends in its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      retry_cnt    <= '0;
      cand_x       <= '0;
      cand_y       <= '0;
      target_x     <= '0;
      target_y     <= '0;
      score        <= '0;
      gen_advance  <= 1'b0;
      target_valid <= 1'b0;
      score_event  <= 1'b0;
      game_won     <= 1'b0;
    end else begin
      state     <= state_nxt;
      retry_cnt <= retry_nxt;
      if (cand_ld) begin
        cand_x <= gen_addr_x;
        cand_y <= gen_addr_y;
      end
      if (accept) begin
        target_x <= tgt_x_nxt;
        target_y <= tgt_y_nxt;
      end
      if (score_inc && score != 4'hF) begin
        score <= score + 4'd1;
      end
      gen_advance  <= (state_nxt == S_ADVANCE);
      target_valid <= (state_nxt == S_ARMED);
      score_event  <= (state_nxt == S_HIT);
      game_won     <= (state_nxt == S_WON);
    end
  end

`ifdef TARGET_SEQ_OCC_CHECK_EN
  // QUERY is only entered from CHECK, on the edge where the candidate register
  // captures gen_addr, so the generator address is the lookup address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_query <= 1'b0;
      occ_x     <= '0;
      occ_y     <= '0;
    end else begin
      occ_query <= (state_nxt == S_QUERY);
      occ_x     <= (state_nxt == S_QUERY) ? gen_addr_x : 8'd0;
      occ_y     <= (state_nxt == S_QUERY) ? gen_addr_y : 7'd0;
    end
  end
`else
  logic unused_body_hit;
  assign unused_body_hit = body_hit;
  assign occ_query       = 1'b0;
  assign occ_x           = '0;
  assign occ_y           = '0;
`endif

endmodule

// File: tb/tb_target_sequencer.sv
`timescale 1ns/1ps
module tb_target_sequencer;

`ifdef TARGET_SEQ_OCC_CHECK_EN
  localparam int OCC = 1;
`else
  localparam int OCC = 0;
`endif
  localparam int LAT = OCC ? 5 : 3;

  typedef enum int {EV_TGT, EV_SCORE, EV_WON} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int x;
    int y;
    int lat;
    int advs;
    int occs;
    int sc;
  } exp_t;
  typedef struct {
    int x;
    int y;
  } addr_t;

  logic       clk;
  logic       rst_n;
  logic       game_run;
  logic [7:0] head_x;
  logic [6:0] head_y;
  logic [7:0] gen_addr_x;
  logic [6:0] gen_addr_y;
  logic       gen_advance;
  logic       occ_query;
  logic [7:0] occ_x;
  logic [6:0] occ_y;
  logic       body_hit;
  logic [7:0] target_x;
  logic [6:0] target_y;
  logic       target_valid;
  logic [3:0] score;
  logic       score_event;
  logic       game_won;

  target_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .game_run    (game_run),
    .head_x      (head_x),
    .head_y      (head_y),
    .gen_addr_x  (gen_addr_x),
    .gen_addr_y  (gen_addr_y),
    .gen_advance (gen_advance),
    .occ_query   (occ_query),
    .occ_x       (occ_x),
    .occ_y       (occ_y),
    .body_hit    (body_hit),
    .target_x    (target_x),
    .target_y    (target_y),
    .target_valid(target_valid),
    .score       (score),
    .score_event (score_event),
    .game_won    (game_won)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  exp_t  exp_q[$];
  addr_t gen_q[$];
  bit    body_mode = 1'b0;
  int    adv_total = 0;

  // monitor-owned state
  int    cyc = 0;
  int    last_adv = 0;
  int    advs = 0;
  int    occs = 0;
  int    occ_lx = 0;
  int    occ_ly = 0;
  bit    tv_prev = 1'b0;
  bit    won_prev = 1'b0;
  bit    q_prev = 1'b0;
  exp_t  e;
  addr_t a;

  // stimulus-owned state
  int cur_x;
  int cur_y;
  int base;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", nm, act, req);
    end
  endtask

  function automatic void exp_tgt(input int x, input int y, input int lat, input int nadv, input int nocc);
    exp_t t;
    t.kind = EV_TGT; t.x = x; t.y = y; t.lat = lat; t.advs = nadv; t.occs = nocc; t.sc = 0;
    exp_q.push_back(t);
  endfunction

  function automatic void exp_ev(input ev_kind_t k, input int sc);
    exp_t t;
    t.kind = k; t.x = 0; t.y = 0; t.lat = 0; t.advs = 0; t.occs = 0; t.sc = sc;
    exp_q.push_back(t);
  endfunction

  function automatic void gen_push(input int x, input int y, input int n);
    addr_t t;
    t.x = x; t.y = y;
    for (int i = 0; i < n; i++) gen_q.push_back(t);
  endfunction

  // sel 0: target_valid high, 1: game_won high, 2: adv_total reaches goal
  task automatic wait_for(input string nm, input int sel, input int goal, input int budget);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(posedge clk); #1;
      case (sel)
        0:       done = target_valid;
        1:       done = game_won;
        default: done = (adv_total >= goal);
      endcase
    end
    chk({nm, "_wait"}, 32'(done), 32'd1);
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_target_xy"}, 32'({target_x, target_y}), 32'd0);
    chk({nm, "_occ"}, 32'({occ_query, occ_x, occ_y}), 32'd0);
    chk({nm, "_flags"}, 32'({gen_advance, target_valid, score_event, game_won}), 32'd0);
    chk({nm, "_score"}, 32'(score), 32'd0);
  endtask

  // Head touches the armed target for one cycle, then moves away.
  task automatic hit_target(input int x, input int y);
    head_x = 8'(x);
    head_y = 7'(y);
    @(posedge clk); #1;
    head_x = 8'd0;
    head_y = 7'd0;
  endtask

  // Monitor plus generator and occupancy-table responders; compares DUT events
  // against the expectation queue.
  initial begin
    gen_addr_x = 8'd0;
    gen_addr_y = 7'd0;
    body_hit   = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        advs = 0; occs = 0; tv_prev = 1'b0; won_prev = 1'b0; q_prev = 1'b0; body_hit = 1'b0;
      end else begin
        body_hit = q_prev && body_mode;
        q_prev   = occ_query;
        if (occ_query) begin
          occs++; occ_lx = int'(occ_x); occ_ly = int'(occ_y);
        end
        if (gen_advance) begin
          adv_total++; advs++; last_adv = cyc;
          if (gen_q.size() > 0) begin
            a = gen_q.pop_front();
            gen_addr_x = 8'(a.x);
            gen_addr_y = 7'(a.y);
          end
        end
        if (target_valid && !tv_prev) begin
          chk("target_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("target_kind", 32'(e.kind), 32'(EV_TGT));
            chk("target_x", 32'(target_x), 32'(e.x));
            chk("target_y", 32'(target_y), 32'(e.y));
            chk("target_latency", 32'(cyc - last_adv), 32'(e.lat));
            chk("gen_advance_count", 32'(advs), 32'(e.advs));
            chk("occ_query_count", 32'(occs), 32'(e.occs));
            if (e.occs > 0) chk("occ_addr", 32'((occ_lx << 8) | occ_ly), 32'((e.x << 8) | e.y));
          end
          advs = 0; occs = 0;
        end
        if (score_event) begin
          chk("score_event_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("score_event_kind", 32'(e.kind), 32'(EV_SCORE));
            chk("score_value", 32'(score), 32'(e.sc));
            chk("hit_target_valid", 32'(target_valid), 32'd0);
          end
        end
        if (game_won && !won_prev) begin
          chk("won_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("won_kind", 32'(e.kind), 32'(EV_WON));
            chk("won_score", 32'(score), 32'(e.sc));
            chk("won_target_valid", 32'(target_valid), 32'd0);
          end
        end
        tv_prev  = target_valid;
        won_prev = game_won;
      end
    end
  end

  initial begin
    rst_n    = 1'b1;
    game_run = 1'b0;
    head_x   = 8'd0;
    head_y   = 7'd0;
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // First target (20,30), clean lookup.
    gen_push(20, 30, 1);
    exp_tgt(20, 30, LAT, 1, OCC);
    game_run = 1'b1;
    wait_for("tgt_20_30", 0, 0, 50);

    // Hit 1; next search sees an out-of-range candidate, then (10,10).
    exp_ev(EV_SCORE, 1);
    gen_push(200, 30, 1);
    gen_push(10, 10, 1);
    exp_tgt(10, 10, LAT, 2, OCC);
    hit_target(20, 30);
    wait_for("tgt_10_10", 0, 0, 50);

    // Hit 2; every candidate rejected -> 15 advances then centre fallback.
    exp_ev(EV_SCORE, 2);
    body_mode = 1'b1;
    gen_push(200, 30, 15);
    exp_tgt(80, 60, 3, 15, 0);
    hit_target(10, 10);
    wait_for("tgt_fallback", 0, 0, 200);

    // Hit 3; retry counter starts fresh after the fallback.
    exp_ev(EV_SCORE, 3);
    body_mode = 1'b0;
    gen_push(200, 30, 1);
    gen_push(30, 40, 1);
    exp_tgt(30, 40, LAT, 2, OCC);
    hit_target(80, 60);
    wait_for("tgt_30_40", 0, 0, 50);

    // game_run drops in the same cycle as a head match: no score.
    head_x = 8'd30; head_y = 7'd40; game_run = 1'b0;
    @(posedge clk); #1;
    head_x = 8'd0; head_y = 7'd0;
    @(posedge clk); #1;
    chk("drop_score_kept", 32'(score), 32'd3);
    chk("drop_target_valid", 32'(target_valid), 32'd0);
    chk("drop_no_score_event", 32'(score_event), 32'd0);

    // Abort a search after 5 rejections; the restart must not inherit them.
    base = adv_total;
    gen_push(200, 30, 6);
    game_run = 1'b1;
    wait_for("abort_adv", 2, base + 6, 100);
    game_run = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_idle_tv", 32'(target_valid), 32'd0);
    gen_push(200, 30, 12);
    gen_push(30, 40, 1);
    exp_tgt(30, 40, LAT, 19, OCC);
    game_run = 1'b1;
    wait_for("tgt_after_abort", 0, 0, 200);
    cur_x = 30; cur_y = 40;

    // Seven more hits take the score from 3 to WIN_SCORE.
    for (int k = 0; k < 7; k++) begin
      exp_ev(EV_SCORE, 4 + k);
      if (k < 6) begin
        gen_push(k * 10 + 11, k * 5 + 7, 1);
        exp_tgt(k * 10 + 11, k * 5 + 7, LAT, 1, OCC);
        hit_target(cur_x, cur_y);
        wait_for("tgt_loop", 0, 0, 50);
        cur_x = k * 10 + 11; cur_y = k * 5 + 7;
      end else begin
        exp_ev(EV_WON, 10);
        hit_target(cur_x, cur_y);
        wait_for("won", 1, 0, 20);
      end
    end

    // WON ignores inputs.
    base = adv_total;
    game_run = 1'b0;
    head_x = 8'(cur_x); head_y = 7'(cur_y);
    repeat (5) @(posedge clk);
    #1;
    chk("won_sticky", 32'(game_won), 32'd1);
    chk("won_tv_low", 32'(target_valid), 32'd0);
    chk("won_score_hold", 32'(score), 32'd10);
    chk("won_no_advance", 32'(adv_total), 32'(base));
    head_x = 8'd0; head_y = 7'd0;

    // Reset in WON clears everything asynchronously.
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_won");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset mid-search (WAIT_OCC with lookup, SETTLE without).
    gen_push(50, 50, 1);
    body_mode = 1'b1;
    base = adv_total;
    game_run = 1'b1;
    wait_for("ms_adv", 2, base + 1, 20);
    repeat (OCC ? 3 : 0) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_search");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    body_mode = 1'b0;
    gen_push(50, 50, 1);
    exp_tgt(50, 50, LAT, 1, OCC);
    wait_for("tgt_after_rst", 0, 0, 50);
    repeat (3) @(posedge clk);
    #1;
    chk("final_score", 32'(score), 32'd0);
    chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
